// File: rtl/cache_bank_switch_ctrl.sv
// Cache-bank switch sequencer: stalls the pipeline, drains the D-cache, then retargets the active bank.
// Optional write-back of the outgoing bank before the swap is enabled by defining FLUSH_ON_SWITCH_EN.
module cache_bank_switch_ctrl #(
    parameter int unsigned NUM_BANKS     = 4,
    parameter int unsigned BANK_ID_W     = 2,
    parameter int unsigned RESET_BANK    = 0,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 switch_req,
    input  logic [BANK_ID_W-1:0] switch_bank_id,
    input  logic                 dcache_busywait,
    input  logic                 flush_done,
    output logic                 flush_req,
    output logic [BANK_ID_W-1:0] active_bank,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic                 switch_busywait,
    output logic                 switch_done,
    output logic                 switch_err,
    output logic [CNT_W-1:0]     switch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
`ifdef FLUSH_ON_SWITCH_EN
        S_FLUSH,
`endif
        S_SWAP,
        S_SETTLE
    } state_t;

    state_t                 state_q, state_d;
    logic [BANK_ID_W-1:0]   pending_id_q, pending_id_d;
    logic [BANK_ID_W-1:0]   active_bank_q, active_bank_d;
    logic [NUM_BANKS-1:0]   bank_sel_q, bank_sel_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [3:0]             settle_q, settle_d;
    logic                   same_done_q, same_done_d;
    logic                   err_q, err_d;

    logic                   req_accept;
    logic                   id_valid;

`ifndef FLUSH_ON_SWITCH_EN
    logic                   unused_flush_done;
    assign unused_flush_done = flush_done;
`endif

    // The request is still held during the retire cycle of an immediate pulse; it must not re-trigger.
    assign req_accept = switch_req && !(same_done_q || err_q);
    assign id_valid   = 32'(switch_bank_id) < NUM_BANKS;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pending_id_q  <= BANK_ID_W'(RESET_BANK);
            active_bank_q <= BANK_ID_W'(RESET_BANK);
            bank_sel_q    <= NUM_BANKS'(1) << RESET_BANK;
            count_q       <= '0;
            settle_q      <= '0;
            same_done_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_id_q  <= pending_id_d;
            active_bank_q <= active_bank_d;
            bank_sel_q    <= bank_sel_d;
            count_q       <= count_d;
            settle_q      <= settle_d;
            same_done_q   <= same_done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_id_d  = pending_id_q;
        active_bank_d = active_bank_q;
        bank_sel_d    = bank_sel_q;
        count_d       = count_q;
        settle_d      = settle_q;
        same_done_d   = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_accept) begin
                    if (!id_valid) begin
                        err_d = 1'b1;
                    end else if (switch_bank_id == active_bank_q) begin
                        same_done_d = 1'b1;
                    end else begin
                        pending_id_d = switch_bank_id;
                        state_d      = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!dcache_busywait) begin
`ifdef FLUSH_ON_SWITCH_EN
                    state_d = S_FLUSH;
`else
                    state_d = S_SWAP;
`endif
                end
            end
`ifdef FLUSH_ON_SWITCH_EN
            S_FLUSH: begin
                if (flush_done) begin
                    state_d = S_SWAP;
                end
            end
`endif
            S_SWAP: begin
                active_bank_d = pending_id_q;
                bank_sel_d    = NUM_BANKS'(1) << pending_id_q;
                if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
                settle_d = 4'(SETTLE_CYCLES - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The last settle cycle releases the stall so the switch instruction retires with the done pulse.
    always_comb begin
        flush_req       = 1'b0;
        switch_busywait = 1'b1;
        switch_done     = same_done_q;
        case (state_q)
            S_IDLE:   switch_busywait = req_accept;
`ifdef FLUSH_ON_SWITCH_EN
            S_FLUSH:  flush_req = 1'b1;
`endif
            S_SETTLE: begin
                switch_busywait = (settle_q != 4'd0);
                switch_done     = (settle_q == 4'd0);
            end
            default:  switch_busywait = 1'b1;
        endcase
    end

    assign switch_err   = err_q;
    assign active_bank  = active_bank_q;
    assign bank_sel     = bank_sel_q;
    assign switch_count = count_q;

endmodule

// File: tb/tb_cache_bank_switch_ctrl.sv
// Scoreboard bench for cache_bank_switch_ctrl (3 banks, 3 settle cycles, 2-bit saturating counter).
// Directed switch vectors push expected pulses; a negedge monitor pops and checks them.
module tb_cache_bank_switch_ctrl;

    logic       clk;
    logic       reset;
    logic       switch_req;
    logic [1:0] switch_bank_id;
    logic       dcache_busywait;
    logic       flush_done;
    logic       flush_req;
    logic [1:0] active_bank;
    logic [2:0] bank_sel;
    logic       switch_busywait;
    logic       switch_done;
    logic       switch_err;
    logic [1:0] switch_count;

    cache_bank_switch_ctrl #(
        .NUM_BANKS(3),
        .BANK_ID_W(2),
        .RESET_BANK(0),
        .SETTLE_CYCLES(3),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switch_req(switch_req),
        .switch_bank_id(switch_bank_id),
        .dcache_busywait(dcache_busywait),
        .flush_done(flush_done),
        .flush_req(flush_req),
        .active_bank(active_bank),
        .bank_sel(bank_sel),
        .switch_busywait(switch_busywait),
        .switch_done(switch_done),
        .switch_err(switch_err),
        .switch_count(switch_count)
    );

`ifdef FLUSH_ON_SWITCH_EN
    localparam int FLUSH_EXTRA = 5;
`else
    localparam int FLUSH_EXTRA = 0;
`endif

    typedef struct {
        logic [1:0] id;
        int         busy;
        bit         is_err;
        logic [1:0] bank;
        logic [2:0] sel;
        logic [1:0] cnt;
        int         lat;
    } vec_t;

    typedef struct {
        bit         is_err;
        logic [1:0] bank;
        logic [2:0] sel;
        logic [1:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fl_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench side of the write-back handshake: answer flush_req on its fifth cycle.
    task automatic flush_respond();
        flush_done = 1'b0;
        if (flush_req) begin
            fl_cnt++;
            if (fl_cnt == 5) flush_done = 1'b1;
        end else begin
            fl_cnt = 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (switch_done || switch_err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, switch_err, switch_done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_err", {31'd0, switch_err}, {31'd0, e.is_err});
                    chk("pulse_done", {31'd0, switch_done}, {31'd0, !e.is_err});
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("active_bank", {30'd0, active_bank}, {30'd0, e.bank});
                    chk("bank_sel", {29'd0, bank_sel}, {29'd0, e.sel});
                    chk("switch_count", {30'd0, switch_count}, {30'd0, e.cnt});
                    chk("pulse_busywait", {31'd0, switch_busywait}, 32'd0);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        bit   seen;
        n    = cyc;
        seen = 1'b0;
        switch_req     = 1'b1;
        switch_bank_id = v.id;
        if (v.busy > 0) begin
            dcache_busywait = 1'b1;
            fork
                begin
                    repeat (v.busy + 1) @(posedge clk);
                    #1 dcache_busywait = 1'b0;
                end
            join_none
        end
        e.is_err = v.is_err;
        e.bank   = v.bank;
        e.sel    = v.sel;
        e.cnt    = v.cnt;
        e.cyc    = n + v.lat + ((v.lat > 1) ? FLUSH_EXTRA : 0);
        sb_q.push_back(e);
        fl_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (switch_done || switch_err) begin
                seen = 1'b1;
                break;
            end
            chk("stall_busywait", {31'd0, switch_busywait}, 32'd1);
`ifndef FLUSH_ON_SWITCH_EN
            chk("flush_req_idle", {31'd0, flush_req}, 32'd0);
`endif
            flush_respond();
            if (k == 1) switch_bank_id = v.id ^ 2'b01;
        end
        if (!seen) chk("pulse_timeout", 32'd0, 32'd1);
        flush_done = 1'b0;
        @(posedge clk);
        #1 switch_req = 1'b0;
        @(negedge clk);
        chk("idle_busywait", {31'd0, switch_busywait}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        bit seen;
        reset           = 1'b1;
        switch_req      = 1'b0;
        switch_bank_id  = 2'd0;
        dcache_busywait = 1'b0;
        flush_done      = 1'b0;

        // id, busy, is_err, bank, sel, cnt, latency
        vecs[0] = '{2'd2, 0, 1'b0, 2'd2, 3'b100, 2'd1, 5};
        vecs[1] = '{2'd2, 0, 1'b0, 2'd2, 3'b100, 2'd1, 1};
        vecs[2] = '{2'd3, 0, 1'b1, 2'd2, 3'b100, 2'd1, 1};
        vecs[3] = '{2'd1, 5, 1'b0, 2'd1, 3'b010, 2'd2, 10};
        vecs[4] = '{2'd0, 0, 1'b0, 2'd0, 3'b001, 2'd3, 5};
        vecs[5] = '{2'd2, 0, 1'b0, 2'd2, 3'b100, 2'd3, 5};
        vecs[6] = '{2'd3, 0, 1'b1, 2'd2, 3'b100, 2'd3, 1};
        vecs[7] = '{2'd0, 1, 1'b0, 2'd0, 3'b001, 2'd3, 6};
        vecs[8] = '{2'd0, 0, 1'b0, 2'd0, 3'b001, 2'd3, 1};
        vecs[9] = '{2'd2, 0, 1'b0, 2'd2, 3'b100, 2'd1, 5};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_active_bank", {30'd0, active_bank}, 32'd0);
        chk("rst_bank_sel", {29'd0, bank_sel}, 32'd1);
        chk("rst_count", {30'd0, switch_count}, 32'd0);
        chk("rst_busywait", {31'd0, switch_busywait}, 32'd0);
        chk("rst_flush_req", {31'd0, flush_req}, 32'd0);

        // A stray flush_done while idle must not disturb the next switch.
        @(posedge clk);
        #1 flush_done = 1'b1;
        @(posedge clk);
        #1 flush_done = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the second settle cycle of a switch to bank 1: no done pulse, reset values return.
        switch_req     = 1'b1;
        switch_bank_id = 2'd1;
        fl_cnt         = 0;
        seen           = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (active_bank == 2'd1) begin
                seen = 1'b1;
                break;
            end
            flush_respond();
        end
        flush_done = 1'b0;
        chk("mid_swap_seen", {31'd0, seen}, 32'd1);
        chk("mid_bank_sel", {29'd0, bank_sel}, 32'b010);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        switch_req = 1'b0;
        @(negedge clk);
        chk("mid_no_done", {31'd0, switch_done}, 32'd0);
        @(negedge clk);
        chk("mid_rst_bank", {30'd0, active_bank}, 32'd0);
        chk("mid_rst_sel", {29'd0, bank_sel}, 32'd1);
        chk("mid_rst_busywait", {31'd0, switch_busywait}, 32'd0);
        chk("mid_rst_count", {30'd0, switch_count}, 32'd0);
        chk("mid_rst_flush_req", {31'd0, flush_req}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        run_vec(vecs[9]);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_bank_switch_ctrl.md
Name: cache_bank_switch_ctrl

Overview:
- Sequences OS-initiated cache-bank switches for the pipelined RISC-V core.
- Receives the switch request decoded in ID and carried to the MEM stage, and stalls the pipeline through a busywait that is ORed into the core's busywait.
- Drains outstanding data-cache activity, then retargets the active bank.
- Generalises the single fixed switch signal to NUM_BANKS contexts, with a bank-ID operand, error reporting and a switch counter.

Parameters:
- NUM_BANKS, 4: number of cache banks/contexts, 2..16.
- BANK_ID_W, 2: width of the bank-ID field; must satisfy 2**BANK_ID_W >= NUM_BANKS.
- RESET_BANK, 0: bank that is active after reset.
- SETTLE_CYCLES, 1: cycles to wait after a swap before release, 1..15.
- CNT_W, 16: width of the switch counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- switch_req  in  1  MEM-stage switch instruction valid; level, held while stalled.
- switch_bank_id  in  BANK_ID_W  requested bank (low bits of rs1 data).
- dcache_busywait  in  1  data cache busy.
- flush_done  in  1  one-cycle pulse from the cache: write-back complete (feature only).
- flush_req  out  1  level request to write back dirty lines of the active bank (feature only).
- active_bank  out  BANK_ID_W  currently selected bank.
- bank_sel  out  NUM_BANKS  one-hot decode of active_bank.
- switch_busywait  out  1  pipeline stall.
- switch_done  out  1  one-cycle pulse when a switch completes.
- switch_err  out  1  one-cycle pulse when the requested ID is out of range.
- switch_count  out  CNT_W  count of completed real switches, saturating.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE, active_bank=RESET_BANK, bank_sel=1<<RESET_BANK, all pulses and flush_req 0, switch_count 0, settle counter 0.
- Reset mid-operation aborts to IDLE with the reset values. The pending ID is discarded and flush_req drops the next edge.
- States: IDLE, DRAIN, FLUSH (feature only), SWAP, SETTLE.
- IDLE, switch_req=1:
  - If id >= NUM_BANKS: switch_err pulses the next cycle, state stays IDLE, no stall beyond the request cycle.
  - If id == active_bank: switch_done pulses the next cycle, count unchanged, state stays IDLE.
  - Otherwise: latch pending_id and go to DRAIN.
- switch_busywait is combinational:
  - 1 when state != IDLE.
  - 1 in IDLE when switch_req=1 and the id is valid and differs from active_bank.
  - 1 in the request cycle of the error and same-bank cases, so the instruction retires in the following cycle together with the pulse.
- DRAIN: when dcache_busywait=0 is sampled, go to FLUSH (feature) or SWAP; otherwise hold.
- FLUSH: assert flush_req; on flush_done=1 go to SWAP. A flush_done arriving outside FLUSH is ignored.
- SWAP (one cycle): active_bank<=pending_id, bank_sel updated, switch_count+1, saturating at all-ones. Then go to SETTLE and load the counter with SETTLE_CYCLES-1.
- SETTLE: count down; at 0, pulse switch_done and go to IDLE. busywait is 0 in the cycle switch_done is high.
- Minimum latency, request cycle to done pulse, with an idle cache and no flush: 3+SETTLE_CYCLES-1 cycles.
- switch_req and switch_bank_id are sampled only in IDLE; changes while busy are ignored.
- The switch sequence never waits on a dcache_busywait asserted after DRAIN.
- bank_sel is always exactly one-hot.

Optional Feature:
- Macro: FLUSH_ON_SWITCH_EN.
- Defined: the FLUSH state exists; the outgoing bank's dirty lines are written back before the swap via the flush_req/flush_done handshake.
- Undefined: no FLUSH state; flush_req is tied to 0 and flush_done is unused. Banks retain dirty data across switches, which is the lazy policy.

Test Plan:
- Reset: assert reset 2 cycles → active_bank=0, bank_sel=4'b0001, switch_count=0, switch_busywait=0.
- Switch to bank 2 with idle cache, SETTLE_CYCLES=1 → busywait high 3 cycles; switch_done pulses on cycle 3; active_bank=2, bank_sel=4'b0100, count=1.
- Same-bank and error requests, with active_bank=2:
  - Request id=2 → done pulse next cycle, count stays 1.
  - With NUM_BANKS=3, request id=3 → switch_err pulse, active_bank unchanged.
- Drain: request bank 1 while dcache_busywait is held high 5 cycles → remains in DRAIN 5 cycles, swap on the first low cycle, done 2 cycles later.
- Flush (FLUSH_ON_SWITCH_EN defined): request bank 3 → flush_req stays high until flush_done is driven 4 cycles later. Then active_bank=3 and done pulses 2 cycles after flush_done.
- Reset mid-SETTLE (SETTLE_CYCLES=8): reset at settle cycle 3 → next cycle active_bank=0, busywait=0, no done pulse; count saturation checked with CNT_W=2 after 5 switches → count=3.
